// File: rtl/split_fsm.sv
// split_fsm: registered 1-to-N_SLAVES splitter for the IOb native bus.
// Accepts one master request at a time and decodes the slave-select field
// m_req[P_SLAVES -: $clog2(N_SLAVES)]. The request is forwarded to the selected
// slave until that slave answers. A registered one-cycle response then goes back
// to the master. Out-of-range selects are answered locally with ERR_DATA.
// Optional feature macro: SPLIT_TIMEOUT_EN. When it is defined, a slave that
// stays silent for TIMEOUT_CYC cycles is abandoned and answered with ERR_DATA.
// Request packing:  {valid, addr[ADDR_W], wdata[DATA_W], wstrb[DATA_W/8]}.
// Response packing: {rdata[DATA_W], ready}.
module split_fsm #(
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 32,
  parameter int          N_SLAVES    = 2,
  parameter int          P_SLAVES    = 1 + ADDR_W + DATA_W + DATA_W/8 - 2,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic [1+ADDR_W+DATA_W+DATA_W/8-1:0]                 m_req,
  output logic [DATA_W:0]                                     m_resp,
  output logic [N_SLAVES*(1+ADDR_W+DATA_W+DATA_W/8)-1:0]      s_req,
  input  logic [N_SLAVES*(DATA_W+1)-1:0]                      s_resp,
  output logic                                                busy,
  output logic                                                s_err
);

  localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W/8;
  localparam int RESP_W = DATA_W + 1;
  localparam int NB     = $clog2(N_SLAVES);
  localparam logic [DATA_W-1:0] ERR_RDATA = DATA_W'(ERR_DATA);

  typedef enum logic [1:0] {IDLE, FWD, ERR, DONE} state_t;

  state_t             state_reg, state_next;
  logic [NB-1:0]      sel_reg, sel_next;
  logic [REQ_W-1:0]   slot_reg  [N_SLAVES];
  logic [REQ_W-1:0]   slot_next [N_SLAVES];
  logic [DATA_W-1:0]  rdata_reg, rdata_next;
  logic               ready_reg, ready_next;
  logic               err_reg, err_next;

`ifdef SPLIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
`endif

  logic               sl_ready [N_SLAVES];
  logic [DATA_W-1:0]  sl_rdata [N_SLAVES];
  logic [NB-1:0]      field;
  logic               field_ok;
  logic               sel_ready;
  logic [DATA_W-1:0]  sel_rdata;

  // Unpack the slave responses and drive each request slot from its own register.
  for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_slot
    assign sl_ready[gi]                 = s_resp[gi*RESP_W];
    assign sl_rdata[gi]                 = s_resp[gi*RESP_W+1 +: DATA_W];
    assign s_req[gi*REQ_W +: REQ_W]     = slot_reg[gi];
  end

  assign field    = m_req[P_SLAVES -: NB];
  assign field_ok = ({1'b0, field} < (NB+1)'(N_SLAVES));
  assign m_resp   = {rdata_reg, ready_reg};
  assign busy     = (state_reg != IDLE);
  assign s_err    = err_reg;

  // Pick the latched slave's response. The latched select never exceeds the
  // slot range while in FWD, so an explicit mux avoids out-of-range indexing.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (sel_reg == NB'(i)) begin
        sel_ready = sl_ready[i];
        sel_rdata = sl_rdata[i];
      end
    end
  end

  // Next-state and datapath decisions; response strobes default low every cycle.
  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    slot_next  = slot_reg;
    rdata_next = rdata_reg;
    ready_next = 1'b0;
    err_next   = 1'b0;
`ifdef SPLIT_TIMEOUT_EN
    cnt_next   = cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (m_req[REQ_W-1]) begin
          sel_next = field;
          if (field_ok) begin
            for (int i = 0; i < N_SLAVES; i++) begin
              if (field == NB'(i)) slot_next[i] = m_req;
            end
`ifdef SPLIT_TIMEOUT_EN
            cnt_next = '0;
`endif
            state_next = FWD;
          end else begin
            state_next = ERR;
          end
        end
      end
      FWD: begin
        if (sel_ready) begin
          // A ready in the last allowed cycle still completes normally.
          for (int i = 0; i < N_SLAVES; i++) slot_next[i] = '0;
          rdata_next = sel_rdata;
          ready_next = 1'b1;
          state_next = DONE;
        end
`ifdef SPLIT_TIMEOUT_EN
        else if (cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
          for (int i = 0; i < N_SLAVES; i++) slot_next[i] = '0;
          rdata_next = ERR_RDATA;
          ready_next = 1'b1;
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
`endif
      end
      ERR: begin
        rdata_next = ERR_RDATA;
        ready_next = 1'b1;
        err_next   = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Datapath registers: latched select, request slots and master response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_reg   <= '0;
      rdata_reg <= '0;
      ready_reg <= 1'b0;
      err_reg   <= 1'b0;
      for (int i = 0; i < N_SLAVES; i++) slot_reg[i] <= '0;
`ifdef SPLIT_TIMEOUT_EN
      cnt_reg   <= '0;
`endif
    end else begin
      sel_reg   <= sel_next;
      rdata_reg <= rdata_next;
      ready_reg <= ready_next;
      err_reg   <= err_next;
      for (int i = 0; i < N_SLAVES; i++) slot_reg[i] <= slot_next[i];
`ifdef SPLIT_TIMEOUT_EN
      cnt_reg   <= cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_split_fsm.sv
// Directed bench for split_fsm: a two-slave instance and a three-slave instance
// share the clock and reset. Both use DATA_W = ADDR_W = 32. The select field is
// therefore the top address bit, or the top two address bits for three slaves.
module tb_split_fsm;

  localparam int REQ_W  = 69;
  localparam int RESP_W = 33;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;

  logic [REQ_W-1:0]     m_req  = '0;
  logic [RESP_W-1:0]    m_resp;
  logic [2*REQ_W-1:0]   s_req;
  logic [2*RESP_W-1:0]  s_resp = '0;
  logic                 busy, s_err;

  logic [REQ_W-1:0]     m_req2  = '0;
  logic [RESP_W-1:0]    m_resp2;
  logic [3*REQ_W-1:0]   s_req2;
  logic [3*RESP_W-1:0]  s_resp2 = '0;
  logic                 busy2, s_err2;

  int n_checks = 0;
  int n_fail   = 0;

  logic [REQ_W-1:0] req_a, req_b;

  split_fsm #(.N_SLAVES(2), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_resp(m_resp),
    .s_req(s_req), .s_resp(s_resp), .busy(busy), .s_err(s_err)
  );

  split_fsm #(.N_SLAVES(3), .TIMEOUT_CYC(8)) dut3 (
    .clk(clk), .rst(rst), .m_req(m_req2), .m_resp(m_resp2),
    .s_req(s_req2), .s_resp(s_resp2), .busy(busy2), .s_err(s_err2)
  );

  always #5 clk = ~clk;

  function automatic logic [REQ_W-1:0] mkreq(input logic [31:0] addr, input logic [31:0] wdata,
                                             input logic [3:0] wstrb);
    return {1'b1, addr, wdata, wstrb};
  endfunction

  function automatic logic [REQ_W-1:0] slot(input logic [255:0] v, input int i);
    return v[i*REQ_W +: REQ_W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state.
    #2;
    check("rst_mresp", 256'(m_resp), 256'(0));
    check("rst_sreq",  256'(s_req),  256'(0));
    check("rst_busy",  256'(busy),   256'(0));
    check("rst_serr",  256'(s_err),  256'(0));
    #11 rst = 1'b1;
    tick();

    // T1: read to slave1; slave1 is ready in its first valid cycle.
    req_a = mkreq(32'h8000_0004, 32'h0, 4'h0);
    m_req = req_a;
    tick();
    check("t1_slot1", 256'(slot(256'(s_req), 1)), 256'(req_a));
    check("t1_slot0", 256'(slot(256'(s_req), 0)), 256'(0));
    check("t1_busy",  256'(busy),   256'(1));
    check("t1_rdy0",  256'(m_resp[0]), 256'(0));
    s_resp[RESP_W +: RESP_W] = {32'h0000_1234, 1'b1};
    tick();
    check("t1_mresp", 256'(m_resp), 256'({32'h0000_1234, 1'b1}));
    check("t1_sreq0", 256'(s_req),  256'(0));
    check("t1_serr",  256'(s_err),  256'(0));
    m_req  = '0;
    s_resp = '0;
    tick();
    check("t1_hold",  256'(m_resp), 256'({32'h0000_1234, 1'b0}));
    check("t1_idle",  256'(busy),   256'(0));
    $display("txn T1 slave1 read done");

    // T2: write to slave0, which answers in its sixth cycle. The master changes
    // the address mid-wait, and slave1 raises a stray ready that must be ignored.
    req_a = mkreq(32'h0000_0100, 32'hA5A5_0000, 4'hF);
    m_req = req_a;
    tick();
    m_req = mkreq(32'h8000_0000, 32'h1111_1111, 4'h1);
    s_resp[RESP_W +: RESP_W] = {32'h0000_0BAD, 1'b1};
    for (int k = 1; k <= 6; k++) begin
      check($sformatf("t2_slot0_c%0d", k), 256'(slot(256'(s_req), 0)), 256'(req_a));
      check($sformatf("t2_slot1_c%0d", k), 256'(slot(256'(s_req), 1)), 256'(0));
      check($sformatf("t2_rdy_c%0d", k),   256'(m_resp[0]), 256'(0));
      if (k == 6) s_resp[0 +: RESP_W] = {32'h0000_CAFE, 1'b1};
      tick();
    end
    check("t2_mresp", 256'(m_resp), 256'({32'h0000_CAFE, 1'b1}));
    check("t2_sreq0", 256'(s_req),  256'(0));
    m_req  = '0;
    s_resp = '0;
    tick();
    check("t2_rdy_off", 256'(m_resp[0]), 256'(0));
    $display("txn T2 slave0 delayed write done");

    // T3: three slaves, select 3 -> decode error; then select 2 -> normal.
    m_req2 = mkreq(32'hC000_0000, 32'h0, 4'h0);
    tick();
    check("t3_sreq",  256'(s_req2),  256'(0));
    check("t3_busy",  256'(busy2),   256'(1));
    check("t3_rdy0",  256'(m_resp2[0]), 256'(0));
    tick();
    check("t3_mresp", 256'(m_resp2), 256'({32'hDEAD_BEEF, 1'b1}));
    check("t3_serr",  256'(s_err2),  256'(1));
    check("t3_sreq2", 256'(s_req2),  256'(0));
    m_req2 = '0;
    tick();
    check("t3_serr0", 256'(s_err2),  256'(0));
    check("t3_hold",  256'(m_resp2), 256'({32'hDEAD_BEEF, 1'b0}));
    check("t3_idle",  256'(busy2),   256'(0));
    $display("txn T3 decode error done");
    req_a  = mkreq(32'h8000_0040, 32'h0, 4'h0);
    m_req2 = req_a;
    tick();
    check("t3b_slot2", 256'(slot(256'(s_req2), 2)), 256'(req_a));
    check("t3b_slot0", 256'(slot(256'(s_req2), 0)), 256'(0));
    s_resp2[2*RESP_W +: RESP_W] = {32'h0000_0077, 1'b1};
    tick();
    check("t3b_mresp", 256'(m_resp2), 256'({32'h0000_0077, 1'b1}));
    check("t3b_serr",  256'(s_err2),  256'(0));
    m_req2  = '0;
    s_resp2 = '0;
    tick();
    $display("txn T3b slave2 read done");

    // T4: back-to-back, slave1 then slave0.
    req_a = mkreq(32'h8000_0010, 32'h0, 4'h0);
    req_b = mkreq(32'h0000_0020, 32'h0BAD_F00D, 4'h3);
    m_req = req_a;
    tick();
    check("t4a_slot1", 256'(slot(256'(s_req), 1)), 256'(req_a));
    check("t4a_slot0", 256'(slot(256'(s_req), 0)), 256'(0));
    s_resp[RESP_W +: RESP_W] = {32'h0000_1111, 1'b1};
    tick();
    check("t4a_mresp", 256'(m_resp), 256'({32'h0000_1111, 1'b1}));
    m_req  = '0;
    s_resp = '0;
    tick();
    check("t4_gap_busy", 256'(busy), 256'(0));
    check("t4_gap_sreq", 256'(s_req), 256'(0));
    m_req = req_b;
    tick();
    check("t4b_slot0", 256'(slot(256'(s_req), 0)), 256'(req_b));
    check("t4b_slot1", 256'(slot(256'(s_req), 1)), 256'(0));
    s_resp[0 +: RESP_W] = {32'h0000_2222, 1'b1};
    tick();
    check("t4b_mresp", 256'(m_resp), 256'({32'h0000_2222, 1'b1}));
    check("t4b_sreq",  256'(s_req),  256'(0));
    m_req  = '0;
    s_resp = '0;
    tick();
    $display("txn T4 back-to-back done");

    // T5: asynchronous reset while forwarding, then a fresh request.
    req_a = mkreq(32'h0000_0008, 32'h0, 4'h0);
    m_req = req_a;
    tick();
    check("t5_fwd", 256'(slot(256'(s_req), 0)), 256'(req_a));
    #2 rst = 1'b0;
    #1;
    check("t5_rst_sreq",  256'(s_req),  256'(0));
    check("t5_rst_mresp", 256'(m_resp), 256'(0));
    check("t5_rst_busy",  256'(busy),   256'(0));
    m_req = '0;
    tick();
    #3 rst = 1'b1;
    req_a = mkreq(32'h8000_0008, 32'h0, 4'h0);
    m_req = req_a;
    tick();
    check("t5_new_slot1", 256'(slot(256'(s_req), 1)), 256'(req_a));
    s_resp[RESP_W +: RESP_W] = {32'h0000_5555, 1'b1};
    tick();
    check("t5_new_mresp", 256'(m_resp), 256'({32'h0000_5555, 1'b1}));
    m_req  = '0;
    s_resp = '0;
    tick();
    $display("txn T5 reset mid-forward done");

`ifdef SPLIT_TIMEOUT_EN
    // T6: slave1 never answers; the splitter gives up after 8 forwarding cycles.
    req_a = mkreq(32'h8000_0100, 32'h0, 4'h0);
    m_req = req_a;
    tick();
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("t6_slot1_c%0d", k), 256'(slot(256'(s_req), 1)), 256'(req_a));
      check($sformatf("t6_rdy_c%0d", k),   256'(m_resp[0]), 256'(0));
      tick();
    end
    check("t6_mresp", 256'(m_resp), 256'({32'hDEAD_BEEF, 1'b1}));
    check("t6_serr",  256'(s_err),  256'(1));
    check("t6_sreq",  256'(s_req),  256'(0));
    m_req = '0;
    tick();
    check("t6_idle", 256'(busy), 256'(0));
    $display("txn T6 timeout done");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
